// File: rtl/trdb_branch_map.sv
// E-Trace branch map: records taken/not-taken outcomes of retired conditional branches,
// one bit per branch, until the packet emitter flushes it.
module trdb_branch_map #(
  parameter int unsigned BMAP_LEN = 31,
  parameter int unsigned CNT_LEN  = $clog2(BMAP_LEN + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                valid_i,
  input  logic                branch_i,
  input  logic                branch_taken_i,
  input  logic                flush_i,
  output logic [BMAP_LEN-1:0] map_o,
  output logic [CNT_LEN-1:0]  branches_o,
  output logic                is_empty_o,
  output logic                is_full_o,
  output logic                overflow_o
);

  logic [BMAP_LEN-1:0] map_d, map_q;
  logic [CNT_LEN-1:0]  cnt_d, cnt_q;
  logic                ovf_d, ovf_q;
  logic                branch_ev;
  logic                full;

  assign branch_ev = valid_i & branch_i;
  assign full      = (cnt_q == CNT_LEN'(BMAP_LEN));

  always_comb begin
    map_d = map_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (flush_i) begin
      // Consumer sampled the old map this cycle, so a coincident branch starts the new map.
      map_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
      if (branch_ev) begin
        map_d[0] = ~branch_taken_i;
        cnt_d    = CNT_LEN'(1);
      end
    end else if (branch_ev) begin
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        for (int unsigned k = 0; k < BMAP_LEN; k++) begin
          if (cnt_q == CNT_LEN'(k)) map_d[k] = ~branch_taken_i;
        end
        cnt_d = cnt_q + CNT_LEN'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      map_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      map_q <= map_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign map_o      = map_q;
  assign branches_o = cnt_q;
  assign is_empty_o = (cnt_q == '0);
  assign is_full_o  = full;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_trdb_branch_map.sv
// Scoreboard bench for trdb_branch_map: a list-of-outcomes model predicts every cycle's outputs.
module tb_trdb_branch_map;

  localparam int unsigned BMAP_LEN = 31;
  localparam int unsigned CNT_LEN  = 5;

  logic                clk;
  logic                rst_n;
  logic                valid, branch, taken, flush;
  logic [BMAP_LEN-1:0] map;
  logic [CNT_LEN-1:0]  branches;
  logic                is_empty, is_full, overflow;

  trdb_branch_map #(.BMAP_LEN(BMAP_LEN), .CNT_LEN(CNT_LEN)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .valid_i       (valid),
    .branch_i      (branch),
    .branch_taken_i(taken),
    .flush_i       (flush),
    .map_o         (map),
    .branches_o    (branches),
    .is_empty_o    (is_empty),
    .is_full_o     (is_full),
    .overflow_o    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [BMAP_LEN-1:0] map;
    int                  cnt;
    bit                  empty;
    bit                  full;
    bit                  ovf;
  } exp_t;

  exp_t expq[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: ordered list of recorded outcomes (1 = not taken) plus a lost-branch flag.
  bit   mq[$];
  bit   movf;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic exp_t model_outputs();
    exp_t e;
    e.map = '0;
    foreach (mq[i]) if (mq[i]) e.map = e.map | (BMAP_LEN'(1) << i);
    e.cnt   = mq.size();
    e.empty = (mq.size() == 0);
    e.full  = (mq.size() == BMAP_LEN);
    e.ovf   = movf;
    return e;
  endfunction

  task automatic model_apply(input bit v, input bit b, input bit t, input bit f);
    if (f) begin
      mq.delete();
      movf = 0;
      if (v && b) mq.push_back(!t);
    end else if (v && b) begin
      if (mq.size() == BMAP_LEN) movf = 1;
      else mq.push_back(!t);
    end
  endtask

  // One cycle: record expected outputs for the state just clocked in, then drive the next inputs.
  task automatic step(input bit v, input bit b, input bit t, input bit f);
    @(posedge clk);
    #1;
    expq.push_back(model_outputs());
    valid  = v;
    branch = b;
    taken  = t;
    flush  = f;
    model_apply(v, b, t, f);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, $urandom_range(0, 1), $urandom_range(0, 1), 1'b0);
  endtask

  task automatic branches_n(input int n, input bit t);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, t, 1'b0);
  endtask

  // Monitor: every cycle the DUT presents a state; compare against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("map_o", map, e.map);
        chk("branches_o", branches, e.cnt);
        chk("is_empty_o", is_empty, e.empty);
        chk("is_full_o", is_full, e.full);
        chk("overflow_o", overflow, e.ovf);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    valid = 0; branch = 0; taken = 0; flush = 0;
    movf  = 0;
    repeat (3) @(negedge clk);
    chk("reset map_o", map, 0);
    chk("reset is_empty_o", is_empty, 1);
    rst_n = 1'b1;

    idle(10);

    // Mixed outcomes, interleaved with non-branch retirements.
    step(1, 1, 1, 0); step(1, 0, 0, 0);
    step(1, 1, 0, 0); step(1, 0, 1, 0);
    step(1, 1, 0, 0); step(1, 0, 0, 0);
    step(1, 1, 1, 0); idle(1);
    @(negedge clk);
    chk("mixed map_o", map, 31'b0110);
    chk("mixed branches_o", branches, 4);
    step(0, 0, 0, 1); idle(1);

    // Fill, overflow, flush.
    branches_n(31, 0); idle(1);
    @(negedge clk);
    chk("full map_o", map, 31'h7FFF_FFFF);
    chk("full is_full_o", is_full, 1);
    step(1, 1, 1, 0); idle(1);
    @(negedge clk);
    chk("overflow_o set", overflow, 1);
    chk("overflow map kept", map, 31'h7FFF_FFFF);
    step(0, 0, 0, 1); idle(1);
    @(negedge clk);
    chk("overflow_o cleared", overflow, 0);

    // Flush with simultaneous branch, partial and full map.
    for (int i = 0; i < 5; i++) step(1, 1, $urandom_range(0, 1), 0);
    step(1, 1, 0, 1); idle(1);
    @(negedge clk);
    chk("flush+br map_o", map, 1);
    chk("flush+br branches_o", branches, 1);
    step(0, 0, 0, 1);
    branches_n(31, 1);
    step(1, 1, 0, 1); idle(1);
    @(negedge clk);
    chk("full flush+br map_o", map, 1);
    chk("full flush+br overflow_o", overflow, 0);

    // Flush alone.
    step(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 1, $urandom_range(0, 1), 0);
    step(0, 1, 1, 1); idle(1);

    // Async reset between edges with 12 branches held.
    for (int i = 0; i < 12; i++) step(1, 1, $urandom_range(0, 1), 0);
    step(0, 0, 0, 0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async map_o", map, 0);
    chk("async branches_o", branches, 0);
    chk("async is_empty_o", is_empty, 1);
    chk("async is_full_o", is_full, 0);
    chk("async overflow_o", overflow, 0);
    valid = 0; branch = 0; flush = 0;
    mq.delete();
    movf = 0;
    #1 rst_n = 1'b1;
    step(1, 1, 0, 0); idle(1);
    @(negedge clk);
    chk("post-reset bit0", map, 1);

    // Randomized traffic; sparse flushes so the map regularly fills and overflows.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 45) == 0);
    idle(2);

    for (int i = 0; i < 10 && expq.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    chk("scoreboard drained", expq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
